// File: rtl/fine_corr_peak_if.sv
// fine_corr_peak_if: sample, coefficient and result bus of the fine-timing correlator.
//
// Signals (direction seen from the correlator, i.e. the slave modport):
//   en        in   sample strobe
//   clr       in   synchronous clear of delay line, pipeline, FSM and index counter
//   x         in   signed input sample (DW bits)
//   coef_we   in   coefficient write strobe
//   coef_addr in   tap index, 0 = newest sample
//   coef_data in   signed coefficient (CW bits)
//   thresh    in   unsigned detection threshold (AW-1 bits)
//   y         out  correlation magnitude (AW bits, MSB always 0)
//   y_vld     out  one-cycle pulse, y updated
//   peak      out  one-cycle pulse, peak found
//   peak_val  out  magnitude at the peak
//   peak_idx  out  sample index of the peak (IW bits)
//   busy      out  peak-search FSM not idle
//
// The master modport is the driving side (upstream logic or a testbench).

interface fine_corr_peak_if #(
  parameter int unsigned DW   = 14,
  parameter int unsigned CW   = 14,
  parameter int unsigned NTAP = 16,
  parameter int unsigned AW   = 32,
  parameter int unsigned IW   = 16
);

  localparam int unsigned AddrW = (NTAP > 1) ? $clog2(NTAP) : 1;

  logic                    en;
  logic                    clr;
  logic signed [DW-1:0]    x;
  logic                    coef_we;
  logic        [AddrW-1:0] coef_addr;
  logic signed [CW-1:0]    coef_data;
  logic        [AW-2:0]    thresh;
  logic        [AW-1:0]    y;
  logic                    y_vld;
  logic                    peak;
  logic        [AW-1:0]    peak_val;
  logic        [IW-1:0]    peak_idx;
  logic                    busy;

  modport master (
    output en, clr, x, coef_we, coef_addr, coef_data, thresh,
    input  y, y_vld, peak, peak_val, peak_idx, busy
  );

  modport slave (
    input  en, clr, x, coef_we, coef_addr, coef_data, thresh,
    output y, y_vld, peak, peak_val, peak_idx, busy
  );

endinterface

// File: rtl/fine_corr_peak.sv
// fine_corr_peak: NTAP-tap real cross-correlator with runtime-loadable coefficients,
// saturating magnitude output and a threshold / peak-search FSM. Reports the index and
// value of the correlation maximum within a WIN-sample window, then ignores HOLDOFF
// further results before it re-arms.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    fine_corr_peak_if.slave (sample strobe/data, coefficient writes, threshold in;
//          magnitude, peak report and busy out)
//
// Configuration macro:
//   FINE_CORR_PRESET_EN  when defined, reset loads a fixed 16-entry coefficient set
//                        (truncated or zero-padded to NTAP); otherwise coefficients
//                        reset to zero and must be written through coef_we.
//
// Timing: the magnitude of sum(b[k] * x[n-k]) is registered on the en edge that captures
// sample n+1 and flagged by y_vld in the following cycle. The FSM consumes y on y_vld
// cycles; the index attached to a y is the index counter minus one at that time.

module fine_corr_peak #(
  parameter int unsigned DW      = 14,
  parameter int unsigned CW      = 14,
  parameter int unsigned NTAP    = 16,
  parameter int unsigned AW      = 32,
  parameter int unsigned WIN     = 16,
  parameter int unsigned HOLDOFF = 64,
  parameter int unsigned IW      = 16
) (
  input logic              clk,
  input logic              rst_n,
  fine_corr_peak_if.slave  bus
);

  localparam int unsigned AddrW  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int unsigned PW     = DW + CW;
  localparam int unsigned CntMax = (WIN > HOLDOFF) ? WIN : HOLDOFF;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;

`ifdef FINE_CORR_PRESET_EN
  // Reference preamble taps; entries beyond the table are zero.
  function automatic logic signed [CW-1:0] coef_rst(input int unsigned k);
    int v;
    case (k)
      0:       v = 4243;
      1:       v = 78;
      2:       v = -268;
      3:       v = 1837;
      4:       v = -7845;
      5:       v = 2396;
      6:       v = 5889;
      7:       v = 797;
      8:       v = -6000;
      9:       v = 7731;
      10:      v = -2938;
      11:      v = 783;
      12:      v = -4221;
      13:      v = -2280;
      14:      v = 1505;
      15:      v = 2351;
      default: v = 0;
    endcase
    return CW'(v);
  endfunction
`endif

  // Delay line and coefficients
  logic signed [DW-1:0] d_q [NTAP];
  logic signed [DW-1:0] d_d [NTAP];
  logic signed [CW-1:0] b_q [NTAP];
  logic signed [CW-1:0] b_d [NTAP];

  // Magnitude stage
  logic signed [AW-1:0] acc;
  logic        [AW-1:0] mag;
  logic        [AW-1:0] y_q, y_d;
  logic                 y_vld_q, y_vld_d;
  logic                 primed_q, primed_d;
  logic        [IW-1:0] idx_q, idx_d;

  // Peak search
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]   max_q, max_d;
  logic [IW-1:0]   midx_q, midx_d;
  logic [IW-1:0]   y_idx;
  logic            peak_q, peak_d;
  logic [AW-1:0]   pval_q, pval_d;
  logic [IW-1:0]   pidx_q, pidx_d;

  // ---------------------------------------------------------------------------
  // Correlation sum and saturating magnitude
  // ---------------------------------------------------------------------------
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAP; k++) begin
      acc = acc + AW'(PW'(d_q[k]) * PW'(b_q[k]));
    end
    // The most negative sum has no positive counterpart in AW bits.
    if (acc == {1'b1, {(AW-1){1'b0}}}) begin
      mag = {1'b0, {(AW-1){1'b1}}};
    end else if (acc[AW-1]) begin
      mag = unsigned'(-acc);
    end else begin
      mag = unsigned'(acc);
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient writes (independent of en and clr)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      b_d[k] = b_q[k];
    end
    if (bus.coef_we) begin
      // Addresses at or above NTAP match no tap and are dropped.
      for (int k = 0; k < NTAP; k++) begin
        if (bus.coef_addr == AddrW'(k)) begin
          b_d[k] = bus.coef_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line, output register, index counter
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      d_d[k] = d_q[k];
    end
    y_d      = y_q;
    y_vld_d  = 1'b0;
    primed_d = primed_q;
    idx_d    = idx_q;

    if (bus.clr) begin
      // clr outranks a coincident en: the sample is dropped.
      for (int k = 0; k < NTAP; k++) begin
        d_d[k] = '0;
      end
      y_d      = '0;
      primed_d = 1'b0;
      idx_d    = '0;
    end else if (bus.en) begin
      d_d[0] = bus.x;
      for (int k = 1; k < NTAP; k++) begin
        d_d[k] = d_q[k-1];
      end
      y_d      = mag;
      // The first en after reset/clr only fills the delay line.
      y_vld_d  = primed_q;
      primed_d = 1'b1;
      idx_d    = idx_q + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold / peak-search FSM, advanced on y_vld cycles only
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    midx_d  = midx_q;
    peak_d  = 1'b0;
    pval_d  = pval_q;
    pidx_d  = pidx_q;
    cnt_inc = cnt_q + CntW'(1);
    // y was produced on the previous en edge, the counter has moved past it by one.
    y_idx   = idx_q - IW'(1);

    if (bus.clr) begin
      // A peak that would have fired on this edge is discarded; the report regs hold.
      state_d = StIdle;
      cnt_d   = '0;
    end else if (y_vld_q) begin
      case (state_q)
        StIdle: begin
          if (y_q > {1'b0, bus.thresh}) begin
            state_d = StSearch;
            max_d   = y_q;
            midx_d  = y_idx;
            cnt_d   = CntW'(1);
          end
        end
        StSearch: begin
          // Strict compare keeps the earliest of equal maxima.
          if (y_q > max_q) begin
            max_d  = y_q;
            midx_d = y_idx;
          end
          cnt_d = cnt_inc;
          if (cnt_inc >= CntW'(WIN)) begin
            peak_d  = 1'b1;
            pval_d  = max_d;
            pidx_d  = midx_d;
            state_d = StHold;
            cnt_d   = '0;
          end
        end
        StHold: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntW'(HOLDOFF)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) begin
        d_q[k] <= '0;
`ifdef FINE_CORR_PRESET_EN
        b_q[k] <= coef_rst(k);
`else
        b_q[k] <= '0;
`endif
      end
      y_q      <= '0;
      y_vld_q  <= 1'b0;
      primed_q <= 1'b0;
      idx_q    <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      max_q    <= '0;
      midx_q   <= '0;
      peak_q   <= 1'b0;
      pval_q   <= '0;
      pidx_q   <= '0;
    end else begin
      for (int k = 0; k < NTAP; k++) begin
        d_q[k] <= d_d[k];
        b_q[k] <= b_d[k];
      end
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
      primed_q <= primed_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      midx_q   <= midx_d;
      peak_q   <= peak_d;
      pval_q   <= pval_d;
      pidx_q   <= pidx_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.y_vld    = y_vld_q;
  assign bus.peak     = peak_q;
  assign bus.peak_val = pval_q;
  assign bus.peak_idx = pidx_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fine_corr_peak.sv
// tb_fine_corr_peak: scoreboard bench for fine_corr_peak. A reference model of the
// delay line predicts every y at the moment a sample is driven and queues it; a monitor
// on the falling edge pops and compares on y_vld and runs a peak-search model on the
// expected values. Directed checks cover the impulse, saturation, coefficient update,
// peak/holdoff, clr and asynchronous reset scenarios.

module tb_fine_corr_peak;

  localparam int unsigned DW      = 14;
  localparam int unsigned CW      = 14;
  localparam int unsigned NTAP    = 16;
  localparam int unsigned AW      = 32;
  localparam int unsigned WIN     = 16;
  localparam int unsigned HOLDOFF = 64;
  localparam int unsigned IW      = 16;
  localparam int unsigned AddrW   = $clog2(NTAP);

`ifdef FINE_CORR_PRESET_EN
  localparam longint PresetB0 = 4243;
`else
  localparam longint PresetB0 = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fine_corr_peak_if #(.DW(DW), .CW(CW), .NTAP(NTAP), .AW(AW), .IW(IW)) bus ();

  fine_corr_peak #(
    .DW(DW), .CW(CW), .NTAP(NTAP), .AW(AW), .WIN(WIN), .HOLDOFF(HOLDOFF), .IW(IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference datapath model
  typedef struct {
    longint      val;
    int unsigned idx;
  } y_t;

  y_t          yq[$];
  longint      dm[NTAP];
  longint      bm[NTAP];
  bit          primed;
  int unsigned m_idx;

  // Reference peak-search model
  int          m_state;   // 0 idle, 1 search, 2 hold
  int          m_cnt;
  longint      m_max;
  int unsigned m_midx;
  bit          pk_pend;
  longint      pk_val;
  int unsigned pk_idx;
  longint      hist_val[$];
  longint      hist_idx[$];

  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v & ((longint'(1) << w) - 1);
    if (t >= (longint'(1) << (w - 1))) t = t - (longint'(1) << w);
    return t;
  endfunction

  function automatic longint preset_coef(input int k);
`ifdef FINE_CORR_PRESET_EN
    longint tbl [16] = '{4243, 78, -268, 1837, -7845, 2396, 5889, 797,
                         -6000, 7731, -2938, 783, -4221, -2280, 1505, 2351};
    return (k < 16) ? tbl[k] : 0;
`else
    return (k < 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset_datapath();
    for (int k = 0; k < NTAP; k++) dm[k] = 0;
    primed = 1'b0;
    m_idx  = 0;
  endtask

  task automatic push_sample(input int xv);
    y_t     e;
    longint sum;
    bus.en = 1'b1;
    bus.x  = DW'(xv);
    if (primed) begin
      sum = 0;
      for (int k = 0; k < NTAP; k++) sum += dm[k] * bm[k];
      if (sum == -(longint'(1) << (AW - 1))) e.val = (longint'(1) << (AW - 1)) - 1;
      else e.val = (sum < 0) ? -sum : sum;
      e.idx = m_idx;
      yq.push_back(e);
    end
    for (int k = NTAP - 1; k > 0; k--) dm[k] = dm[k-1];
    dm[0]  = sx(xv, DW);
    primed = 1'b1;
    m_idx  = (m_idx + 1) % (1 << IW);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AddrW'(a);
    bus.coef_data = CW'(v);
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    bm[a] = sx(v, CW);
  endtask

  task automatic do_clr(input bit with_en, input int xv);
    bus.clr = 1'b1;
    bus.en  = with_en;
    bus.x   = DW'(xv);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    model_reset_datapath();
  endtask

  task automatic fsm_step(input longint yv, input int unsigned yi);
    case (m_state)
      0: if (yv > longint'(bus.thresh)) begin
        m_state = 1; m_max = yv; m_midx = yi; m_cnt = 1;
      end
      1: begin
        if (yv > m_max) begin m_max = yv; m_midx = yi; end
        m_cnt++;
        if (m_cnt >= WIN) begin
          pk_pend = 1'b1; pk_val = m_max; pk_idx = m_midx; m_state = 2; m_cnt = 0;
        end
      end
      default: begin
        m_cnt++;
        if (m_cnt >= HOLDOFF) begin m_state = 0; m_cnt = 0; end
      end
    endcase
  endtask

  always @(negedge clk) begin : monitor
    y_t e;
    if (!rst_n) begin
      yq.delete();
      m_state = 0;
      m_cnt   = 0;
      pk_pend = 1'b0;
    end else begin
      check_eq("busy", bus.busy, m_state != 0);
      check_eq("peak", bus.peak, pk_pend);
      if (pk_pend) begin
        check_eq("peak_val", bus.peak_val, pk_val);
        check_eq("peak_idx", bus.peak_idx, pk_idx);
      end
      if (bus.peak) begin
        hist_val.push_back(bus.peak_val);
        hist_idx.push_back(bus.peak_idx);
      end
      pk_pend = 1'b0;
      if (bus.y_vld) begin
        if (yq.size() == 0) begin
          check_eq("y_vld_extra", 1, 0);
        end else begin
          e = yq.pop_front();
          check_eq("y", bus.y, e.val);
          if (!bus.clr) fsm_step(e.val, e.idx);
        end
      end
      if (bus.clr) begin
        m_state = 0;
        m_cnt   = 0;
      end
    end
  end

  function automatic int xval(input int i);
    case (i)
      0:       return 500;
      1:       return 1200;
      2, 3:    return 3000;
      4:       return 2500;
      27:      return 5000;   // lands inside holdoff
      89:      return 4000;   // after holdoff has expired
      default: return 200;
    endcase
  endfunction

  initial begin
    int base;
    int imp_exp [5] = '{100, 200, 300, 400, 0};

    bus.en = 0; bus.clr = 0; bus.x = '0;
    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.thresh = '1;
    for (int k = 0; k < NTAP; k++) bm[k] = preset_coef(k);
    model_reset_datapath();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_y", bus.y, 0);
    check_eq("rst_y_vld", bus.y_vld, 0);
    check_eq("rst_peak", bus.peak, 0);
    check_eq("rst_peak_val", bus.peak_val, 0);
    check_eq("rst_peak_idx", bus.peak_idx, 0);
    check_eq("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Reset coefficients: single x=1 reads out b[0]
    push_sample(1);
    check_eq("first_en_no_vld", bus.y_vld, 0);
    push_sample(0);
    check_eq("rst_coef_y", bus.y, PresetB0);
    for (int k = 0; k < NTAP; k++) write_coef(k, 0);

    // Impulse through b = 1,2,3,4
    for (int k = 0; k < 4; k++) write_coef(k, k + 1);
    do_clr(1'b0, 0);
    push_sample(100);
    for (int i = 0; i < 5; i++) begin
      push_sample(0);
      check_eq("impulse_y", bus.y, imp_exp[i]);
    end

    // Most negative product, magnitude output
    for (int k = 1; k < 4; k++) write_coef(k, 0);
    write_coef(0, -8192);
    push_sample(-8192);
    push_sample(8192);
    check_eq("neg_y0", bus.y, 67108864);
    push_sample(0);
    check_eq("neg_y1", bus.y, 67108864);

    // Coefficient change while streaming
    write_coef(0, 1);
    repeat (4) push_sample(50);
    check_eq("coef_old_y", bus.y, 50);
    write_coef(0, 2);
    push_sample(50);
    check_eq("coef_new_y", bus.y, 100);
    push_sample(50);

    // Peak search and holdoff
    bus.thresh = (AW-1)'(1000);
    write_coef(0, 1);
    do_clr(1'b0, 0);
    base = hist_val.size();
    for (int i = 0; i < 120; i++) push_sample(xval(i));
    repeat (3) @(posedge clk);
    #1;
    check_eq("peak_count", hist_val.size() - base, 2);
    if (hist_val.size() >= base + 2) begin
      check_eq("peak1_val", hist_val[base], 3000);
      check_eq("peak1_idx", hist_idx[base], 3);
      check_eq("peak2_val", hist_val[base+1], 4000);
      check_eq("peak2_idx", hist_idx[base+1], 90);
    end

    // clr during SEARCH, with a coincident sample that must be dropped
    do_clr(1'b0, 0);
    repeat (4) push_sample(2000);
    check_eq("search_busy", bus.busy, 1);
    base = hist_val.size();
    do_clr(1'b1, 7777);
    check_eq("clr_busy", bus.busy, 0);
    push_sample(0);
    check_eq("clr_first_en_no_vld", bus.y_vld, 0);
    push_sample(0);
    check_eq("clr_second_en_vld", bus.y_vld, 1);
    check_eq("clr_dropped_y", bus.y, 0);
    repeat (20) push_sample(0);
    check_eq("clr_no_peak", hist_val.size() - base, 0);

    // Asynchronous reset in the middle of SEARCH
    repeat (5) push_sample(3000);
    check_eq("search2_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_y", bus.y, 0);
    check_eq("arst_y_vld", bus.y_vld, 0);
    check_eq("arst_peak_val", bus.peak_val, 0);
    check_eq("arst_peak_idx", bus.peak_idx, 0);
    for (int k = 0; k < NTAP; k++) bm[k] = preset_coef(k);
    model_reset_datapath();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_sample(5);
    push_sample(5);
    check_eq("arst_coef_y", bus.y, PresetB0 * 5);
    push_sample(0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("y_missing", yq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
